// File: rtl/btb_update_scheduler_if.sv
// Update/write-port bundle for btb_update_scheduler: branch-resolution handshake
// from execute plus the BTB single write port driven toward the table.
interface btb_update_scheduler_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 4
);
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_taken;

  logic              btb_we;
  logic [IDX_W-1:0]  btb_index;
  logic [ADDR_W-1:0] btb_pc;
  logic [ADDR_W-1:0] btb_target;
  logic              btb_valid;

  // Execute-side requester and BTB storage as seen from outside the scheduler
  modport master (
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  upd_ready,
    input  btb_we, btb_index, btb_pc, btb_target, btb_valid
  );

  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output upd_ready,
    output btb_we, btb_index, btb_pc, btb_target, btb_valid
  );
endinterface

// File: rtl/btb_update_scheduler.sv
// Owns the BTB write port: queues branch resolutions and runs full-table invalidate sweeps.
// Optional BTB_NOTTAKEN_INVAL_EN: not-taken resolutions evict their entry instead of being dropped.
module btb_update_scheduler #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned QDEPTH  = 4,
  localparam int unsigned IDX_W  = $clog2(ENTRIES),
  localparam int unsigned QPTR_W = $clog2(QDEPTH),
  localparam int unsigned QCNT_W = QPTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  btb_update_scheduler_if.slave bus,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic                  btb_lookup_en,
  output logic [QCNT_W-1:0]     q_count
);

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              valid;
  } wr_t;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [QPTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [QCNT_W-1:0] count_q, count_d, remain;
  wr_t               mem [QDEPTH];
  wr_t               out_q, out_d, new_e;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              lookup_q, lookup_d;
  logic              ready_c, push, pop, keep;

  // Entry formed from the incoming resolution and whether it is worth a write
  always_comb begin
    new_e.index = bus.upd_pc[IDX_W-1:0];
    new_e.pc    = bus.upd_pc;
`ifdef BTB_NOTTAKEN_INVAL_EN
    new_e.target = bus.upd_taken ? bus.upd_target : '0;
    new_e.valid  = bus.upd_taken;
    keep         = 1'b1;
`else
    new_e.target = bus.upd_target;
    new_e.valid  = 1'b1;
    keep         = bus.upd_taken;
`endif
  end

  // Next-state, FIFO bookkeeping and next registered write-port values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    remain   = count_q;
    out_d    = '0;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ready_c  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        ready_c = (count_q < QCNT_W'(QDEPTH)) && !flush_req;
        if (flush_req) begin
          // Stale queued updates are discarded; sweep index 0 goes out next cycle
          state_d = S_FLUSH;
          cnt_d   = '0;
          wptr_d  = '0;
          rptr_d  = '0;
          count_d = '0;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          push    = bus.upd_valid && ready_c && keep;
          pop     = (count_q != '0);
          rptr_d  = rptr_q + QPTR_W'(pop);
          wptr_d  = wptr_q + QPTR_W'(push);
          remain  = count_q - QCNT_W'(pop);
          count_d = remain + QCNT_W'(push);
          // The FIFO head is mirrored into the output register each cycle
          if (count_d != '0) begin
            we_d  = 1'b1;
            out_d = (remain != '0) ? mem[rptr_d] : new_e;
          end
        end
      end

      S_FLUSH: begin
        busy_d = 1'b1;
        if (cnt_q == IDX_W'(ENTRIES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d       = cnt_q + IDX_W'(1);
          we_d        = 1'b1;
          out_d.index = cnt_d;
        end
      end

      S_DONE: begin
        state_d = S_RUN;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    lookup_d = !busy_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      out_q    <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lookup_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lookup_q <= lookup_d;
    end
  end

  // Queue storage needs no reset; pointers and count define what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= new_e;
    end
  end

  assign bus.upd_ready  = ready_c && !reset;
  assign bus.btb_we     = we_q;
  assign bus.btb_index  = out_q.index;
  assign bus.btb_pc     = out_q.pc;
  assign bus.btb_target = out_q.target;
  assign bus.btb_valid  = out_q.valid;
  assign flush_busy     = busy_q;
  assign flush_done     = done_q;
  assign btb_lookup_en  = lookup_q;
  assign q_count        = count_q;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Scoreboard bench for btb_update_scheduler: stimulus queues expected writes and
// per-cycle status values; a negedge monitor pops and compares them.
module tb_btb_update_scheduler;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned QCNT_W = 3;

  localparam int K_READY  = 0;
  localparam int K_BUSY   = 1;
  localparam int K_DONE   = 2;
  localparam int K_LOOKUP = 3;
  localparam int K_QCNT   = 4;
  localparam int K_WE     = 5;

  typedef struct {
    int                cyc;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tgt;
    logic              v;
  } wr_exp_t;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } st_exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush_req = 1'b0;
  logic              flush_busy, flush_done, btb_lookup_en;
  logic [QCNT_W-1:0] q_count;

  btb_update_scheduler_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  btb_update_scheduler #(.ADDR_W(32), .ENTRIES(16), .QDEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .flush_req     (flush_req),
    .flush_busy    (flush_busy),
    .flush_done    (flush_done),
    .btb_lookup_en (btb_lookup_en),
    .q_count       (q_count)
  );

  wr_exp_t     wq[$];
  st_exp_t     sq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          end_req = 1'b0;
  bit          end_ack = 1'b0;
  wr_exp_t     mon_e;
  logic [31:0] mon_act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_READY:  return "upd_ready";
      K_BUSY:   return "flush_busy";
      K_DONE:   return "flush_done";
      K_LOOKUP: return "btb_lookup_en";
      K_QCNT:   return "q_count";
      default:  return "btb_we";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int k);
    case (k)
      K_READY:  return 32'(bus.upd_ready);
      K_BUSY:   return 32'(flush_busy);
      K_DONE:   return 32'(flush_done);
      K_LOOKUP: return 32'(btb_lookup_en);
      K_QCNT:   return 32'(q_count);
      default:  return 32'(bus.btb_we);
    endcase
  endfunction

  // Monitor: all comparisons happen here, away from the rising edge
  always @(negedge clk) begin
    while (wq.size() > 0 && wq[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_write cyc=%0d: no write seen, required idx=%0d pc=%h at cyc %0d",
               cyc, wq[0].idx, wq[0].pc, wq[0].cyc);
      void'(wq.pop_front());
    end
    if (bus.btb_we === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d: got idx=%0d pc=%h tgt=%h valid=%b, required no write",
                 cyc, bus.btb_index, bus.btb_pc, bus.btb_target, bus.btb_valid);
      end else begin
        mon_e = wq.pop_front();
        if (mon_e.cyc != cyc || bus.btb_index !== mon_e.idx || bus.btb_pc !== mon_e.pc ||
            bus.btb_target !== mon_e.tgt || bus.btb_valid !== mon_e.v) begin
          errors++;
          $display("FAIL write_data cyc=%0d: got idx=%0d pc=%h tgt=%h valid=%b, required cyc=%0d idx=%0d pc=%h tgt=%h valid=%b",
                   cyc, bus.btb_index, bus.btb_pc, bus.btb_target, bus.btb_valid,
                   mon_e.cyc, mon_e.idx, mon_e.pc, mon_e.tgt, mon_e.v);
        end
      end
    end else if (bus.btb_we !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL btb_we_unknown cyc=%0d: got %b, required 0 or 1", cyc, bus.btb_we);
    end
    for (int i = sq.size() - 1; i >= 0; i--) begin
      if (sq[i].cyc == cyc) begin
        checks++;
        mon_act = sample(sq[i].kind);
        if (mon_act !== 32'(sq[i].val)) begin
          errors++;
          $display("FAIL %s cyc=%0d: got %0h, required %0h", kname(sq[i].kind), cyc, mon_act, sq[i].val);
        end
        sq.delete(i);
      end
    end
    if (end_req && !end_ack) begin
      checks++;
      if (wq.size() != 0 || sq.size() != 0) begin
        errors++;
        $display("FAIL pending_expectations: got %0d writes and %0d status items left, required 0",
                 wq.size(), sq.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_st(input int c, input int k, input int v);
    st_exp_t s;
    s.cyc = c; s.kind = k; s.val = v;
    sq.push_back(s);
  endtask

  task automatic exp_wr(input int c, input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] pc,
                        input logic [ADDR_W-1:0] tgt, input logic v);
    wr_exp_t w;
    w.cyc = c; w.idx = idx; w.pc = pc; w.tgt = tgt; w.v = v;
    wq.push_back(w);
  endtask

  task automatic offer(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt, input logic taken);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = taken;
  endtask

  task automatic idle();
    bus.upd_valid = 1'b0;
  endtask

  // Flush sampled at rising edge n: sweep index k visible in cycle n+k, done pulse in n+16
  task automatic expect_flush(input int n);
    for (int k = 0; k < 16; k++) exp_wr(n + k, IDX_W'(k), '0, '0, 1'b0);
    exp_st(n - 1, K_LOOKUP, 1);
    exp_st(n, K_QCNT, 0);
    for (int c = n; c <= n + 16; c++) begin
      exp_st(c, K_LOOKUP, 0);
      exp_st(c, K_READY, 0);
      exp_st(c, K_BUSY, 1);
    end
    exp_st(n + 15, K_DONE, 0);
    exp_st(n + 16, K_DONE, 1);
    exp_st(n + 16, K_WE, 0);
    exp_st(n + 17, K_DONE, 0);
    exp_st(n + 17, K_BUSY, 0);
    exp_st(n + 17, K_LOOKUP, 1);
    exp_st(n + 17, K_READY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] pcs  [5];
    logic [ADDR_W-1:0] tgts [5];
    logic [ADDR_W-1:0] pv;
    int f, n;
    pcs  = '{32'h0000_3001, 32'h0000_3012, 32'h0000_30FF, 32'h0000_3102, 32'h0000_3000};
    tgts = '{32'h0000_A001, 32'h0000_A002, 32'h0000_A003, 32'h0000_A004, 32'h0000_A005};
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0;

    // Reset state
    tick(); tick();
    exp_st(cyc, K_READY, 0);
    exp_st(cyc, K_WE, 0);
    exp_st(cyc, K_BUSY, 0);
    exp_st(cyc, K_DONE, 0);
    exp_st(cyc, K_LOOKUP, 1);
    exp_st(cyc, K_QCNT, 0);
    tick();
    reset = 1'b0;
    exp_st(cyc, K_READY, 1);
    tick();

    // Single taken update: written the cycle after acceptance
    offer(32'h0000_1004, 32'h0000_2000, 1'b1);
    exp_st(cyc, K_READY, 1);
    exp_wr(cyc + 1, 4'd4, 32'h0000_1004, 32'h0000_2000, 1'b1);
    tick();
    idle();
    exp_st(cyc + 1, K_QCNT, 0);
    exp_st(cyc + 1, K_WE, 0);
    tick(); tick();

    // Five back-to-back taken updates, two sharing index 2
    for (int i = 0; i < 5; i++) begin
      pv = pcs[i];
      offer(pv, tgts[i], 1'b1);
      exp_st(cyc, K_READY, 1);
      exp_wr(cyc + 1, pv[IDX_W-1:0], pv, tgts[i], 1'b1);
      tick();
    end
    idle();
    exp_st(cyc + 1, K_QCNT, 0);
    tick(); tick(); tick();

    // Flush right behind two updates; flush_req held into the sweep is ignored
    offer(32'h1111_0108, 32'hAAAA_0000, 1'b1);
    exp_wr(cyc + 1, 4'd8, 32'h1111_0108, 32'hAAAA_0000, 1'b1);
    tick();
    offer(32'h2222_010B, 32'hBBBB_0000, 1'b1);
    exp_wr(cyc + 1, 4'd11, 32'h2222_010B, 32'hBBBB_0000, 1'b1);
    tick();
    idle();
    flush_req = 1'b1;
    f = cyc;
    n = f + 1;
    exp_st(f, K_READY, 0);
    expect_flush(n);
    tick(); tick(); tick();
    flush_req = 1'b0;
    while (cyc < n + 19) tick();

    // Update and flush offered together: flush wins, update not accepted
    offer(32'h0000_4005, 32'h0000_9999, 1'b1);
    flush_req = 1'b1;
    f = cyc;
    n = f + 1;
    exp_st(f, K_READY, 0);
    expect_flush(n);
    tick();
    idle();
    flush_req = 1'b0;
    while (cyc < n + 19) tick();

    // Reset while sweep index 7 is on the write port
    flush_req = 1'b1;
    f = cyc;
    n = f + 1;
    for (int k = 0; k < 8; k++) exp_wr(n + k, IDX_W'(k), '0, '0, 1'b0);
    exp_st(n, K_BUSY, 1);
    exp_st(n + 7, K_READY, 0);
    exp_st(n + 7, K_LOOKUP, 0);
    exp_st(n + 8, K_WE, 0);
    exp_st(n + 8, K_BUSY, 0);
    exp_st(n + 8, K_LOOKUP, 1);
    exp_st(n + 8, K_DONE, 0);
    exp_st(n + 9, K_READY, 1);
    exp_st(n + 9, K_LOOKUP, 1);
    exp_st(n + 9, K_QCNT, 0);
    for (int c = n + 9; c <= n + 17; c++) exp_st(c, K_DONE, 0);
    tick();
    flush_req = 1'b0;
    while (cyc < n + 7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    while (cyc < n + 19) tick();

    // Not-taken resolution at index 12, followed by a taken one to the same index
    offer(32'h0000_100C, 32'h5555_0000, 1'b0);
    exp_st(cyc, K_READY, 1);
`ifdef BTB_NOTTAKEN_INVAL_EN
    exp_wr(cyc + 1, 4'd12, 32'h0000_100C, 32'h0000_0000, 1'b0);
`else
    exp_st(cyc + 1, K_WE, 0);
    exp_st(cyc + 1, K_QCNT, 0);
`endif
    tick();
    offer(32'h0000_100C, 32'h0000_6000, 1'b1);
    exp_st(cyc, K_READY, 1);
    exp_wr(cyc + 1, 4'd12, 32'h0000_100C, 32'h0000_6000, 1'b1);
    tick();
    idle();
    tick(); tick(); tick();

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) tick();
    if (!end_ack) begin
      $display("FAIL end_handshake: monitor did not acknowledge, required acknowledgement");
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_update_scheduler.md
# btb_update_scheduler

Sequences all writes into the 16-entry branch target buffer. Owns the BTB's single write port and shares it between two requesters: branch resolutions from execute, buffered in a small FIFO, and a full-table invalidate sweep triggered on context switch or self-modifying-code flush. Sits between the execute-stage branch unit and the BTB storage, and gates fetch-side lookups while the table is being invalidated.

## Interface

- ADDR_W, 32, PC and target width
- ENTRIES, 16, BTB entries, power of two; IDX_W = log2(ENTRIES)
- QDEPTH, 4, update FIFO depth, power of two, minimum 2

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- upd_valid  in  1  branch resolution offered
- upd_ready  out  1  resolution accepted when upd_valid && upd_ready
- upd_pc  in  ADDR_W  PC of resolved branch
- upd_target  in  ADDR_W  resolved target
- upd_taken  in  1  branch resolved taken
- flush_req  in  1  level; request full invalidate
- flush_busy  out  1  sweep in progress
- flush_done  out  1  one-cycle pulse at sweep end
- btb_we  out  1  BTB write strobe
- btb_index  out  IDX_W  entry written
- btb_pc  out  ADDR_W  PC tag to write
- btb_target  out  ADDR_W  target to write
- btb_valid  out  1  valid bit to write
- btb_lookup_en  out  1  fetch may use BTB hits; equals !flush_busy
- q_count  out  log2(QDEPTH)+1  FIFO occupancy

## Operation

- Index is always upd_pc[IDX_W-1:0], which is pc[3:0] for ENTRIES=16.
- The state machine has three states: RUN, FLUSH, DONE. Reset enters RUN.
- **RUN**
  - upd_ready = (q_count < QDEPTH) && !flush_req. No same-cycle pop bypass.
  - A taken update is pushed as {index, pc, target, valid=1}.
  - Not-taken handling is set in Configuration.
  - Each cycle the FIFO is non-empty, one entry is popped and driven as a BTB write on the next cycle.
  - Push and pop in the same cycle leave q_count unchanged.
- **RUN -> FLUSH** on flush_req. Flush wins over any same-cycle update: upd_ready is 0, so nothing is accepted.
  - The FIFO is cleared (q_count = 0). Queued entries are stale and are discarded.
  - A pop in progress that cycle is suppressed.
- **FLUSH**
  - Sweep counter runs 0..ENTRIES-1. One write per cycle: btb_index = counter, btb_valid = 0, btb_pc = 0, btb_target = 0.
  - upd_ready = 0. flush_req is ignored.
  - After index ENTRIES-1 is written, go to DONE.
- **DONE**
  - flush_done = 1 for this one cycle. btb_we = 0, upd_ready = 0.
  - Go to RUN next cycle.
- **Reset values:** btb_we, btb_index, btb_pc, btb_target, btb_valid, flush_busy, flush_done, q_count all 0. btb_lookup_en = 1. upd_ready = 0 while reset is high.
- **Reset mid-sweep:** the sweep aborts, no flush_done pulse is produced, and the block returns to RUN with an empty FIFO.

## Timing

- Update accepted at edge N (FIFO empty): btb_we = 1 with its data during cycle N+1.
- Back-to-back accepts are written on consecutive cycles; sustained throughput is 1 write per cycle.
- All btb_* outputs, flush_busy and flush_done are registered. upd_ready is combinational from state, q_count and flush_req.
- flush_req sampled high at edge N:
  - flush_busy is high from cycle N+1 through N+ENTRIES+1.
  - Writes to indices 0..15 occur in cycles N+1..N+16.
  - flush_done is high in cycle N+17.
  - upd_ready can be 1 again from cycle N+18.
- btb_lookup_en is low for exactly ENTRIES+1 cycles per flush.
- If two queued updates target the same index, they are written in arrival order, so the last write wins.

## Configuration

- **BTB_NOTTAKEN_INVAL_EN**
  - Defined: a not-taken update is pushed as {index, pc, target=0, valid=0}, which evicts the stale entry. It consumes FIFO space and a write cycle.
  - Undefined: a not-taken update is accepted (the handshake completes) but dropped. There is no push and no BTB write.

## Test plan

- Reset, then one taken update (pc=0x0000_1004, target=0x0000_2000) -> next cycle btb_we=1, btb_index=4, btb_pc=0x1004, btb_target=0x2000, btb_valid=1; q_count back to 0.
- Pop write stalled externally by holding flush_req=0 and pushing 5 taken updates on consecutive cycles -> all 5 accepted, written on consecutive cycles in order, upd_ready never drops (q_count ≤ 1).
- flush_req with 2 updates queued -> queue discarded, 16 writes with valid=0 for indices 0..15, flush_done pulse at cycle N+17, btb_lookup_en low for 17 cycles, upd_ready low throughout.
- upd_valid and flush_req asserted in the same cycle -> update not accepted (upd_ready=0), flush proceeds normally.
- Reset asserted at sweep index 7 -> no further writes, no flush_done, the cycle after reset deasserts shows upd_ready=1 and btb_lookup_en=1.
- Not-taken update at pc=0x0000_100C -> with BTB_NOTTAKEN_INVAL_EN: write index 12, valid=0; without it: handshake completes, no btb_we.
